// File: rtl/exe_stage_reg_pkg.sv
// Shared definitions for the EX/MEM pipeline boundary: default widths,
// NZCV bit positions, and the registered memory/writeback control bundle.
package exe_stage_reg_pkg;

   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned REG_W_DEF  = 4;
   localparam int unsigned CNT_W_DEF  = 32;
   localparam int unsigned STATUS_W   = 4;

   // Bit positions inside the {N,Z,C,V} status word
   localparam int unsigned ST_N = 3;
   localparam int unsigned ST_Z = 2;
   localparam int unsigned ST_C = 1;
   localparam int unsigned ST_V = 0;

   // Control bits carried alongside the ALU result into the memory stage
   typedef struct packed {
      logic                 wb_en;
      logic                 mem_r_en;
      logic                 mem_w_en;
      logic [REG_W_DEF-1:0] dest;
   } exmem_ctrl_t;

   // Assemble individual ALU flags into the status word layout
   function automatic logic [STATUS_W-1:0] pack_nzcv(input logic n, input logic z,
                                                      input logic c, input logic v);
      logic [STATUS_W-1:0] w;
      w       = '0;
      w[ST_N] = n;
      w[ST_Z] = z;
      w[ST_C] = c;
      w[ST_V] = v;
      return w;
   endfunction

endpackage

// File: rtl/exe_stage_reg_status_reg.sv
// NZCV status register with load enable.
// Macro STATUS_BYPASS_EN: when defined, a flag load is forwarded to the
// outputs in the same cycle; otherwise outputs are purely registered.
// Ports:
//   clk, rst     clock, synchronous active-low reset
//   i_load       load i_flags at the next edge
//   i_flags      incoming {N,Z,C,V}
//   o_status     current (or bypassed) {N,Z,C,V}
//   o_carry      C bit of o_status, fed back to the ALU carry input
module status_reg
   import exe_stage_reg_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                i_load,
   input  logic [STATUS_W-1:0] i_flags,
   output logic [STATUS_W-1:0] o_status,
   output logic                o_carry
);

   logic [STATUS_W-1:0] r_status;

   // Flag storage
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_status <= '0;
      end else if (i_load) begin
         r_status <= i_flags;
      end
   end

`ifdef STATUS_BYPASS_EN
   // Forward the pending load so a dependent instruction needs no stall
   assign o_status = i_load ? i_flags : r_status;
`else
   assign o_status = r_status;
`endif

   assign o_carry = o_status[ST_C];

endmodule

// File: rtl/exe_stage_reg.sv
// EX/MEM pipeline register with valid/ready handshake, NZCV status
// ownership and retire/stall performance counters.
// Macro STATUS_BYPASS_EN (see status_reg) selects same-cycle flag forwarding.
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   flush                    kill incoming instruction and held entry
//   valid_in / ready_out     upstream handshake (ready_out is combinational)
//   alu_result, flag_*       ALU outputs; s_bit enables the status update
//   wb_en, mem_*_en, dest    control bundle; val_rm store data; pc_in PC
//   valid_out / ready_in     downstream handshake
//   *_q                      registered payload
//   status, carry_to_alu     {N,Z,C,V} and its C bit
//   retired_cnt, stall_cnt   accepted instructions, backpressure cycles
module exe_stage_reg
   import exe_stage_reg_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned REG_W  = REG_W_DEF,
   parameter int unsigned CNT_W  = CNT_W_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   input  logic                valid_in,
   output logic                ready_out,
   input  logic [DATA_W-1:0]   alu_result,
   input  logic                flag_n,
   input  logic                flag_z,
   input  logic                flag_c,
   input  logic                flag_v,
   input  logic                s_bit,
   input  logic                wb_en,
   input  logic                mem_r_en,
   input  logic                mem_w_en,
   input  logic [REG_W-1:0]    dest,
   input  logic [DATA_W-1:0]   val_rm,
   input  logic [DATA_W-1:0]   pc_in,
   output logic                valid_out,
   input  logic                ready_in,
   output logic [DATA_W-1:0]   alu_result_q,
   output logic [DATA_W-1:0]   val_rm_q,
   output logic [DATA_W-1:0]   pc_q,
   output logic                wb_en_q,
   output logic                mem_r_en_q,
   output logic                mem_w_en_q,
   output logic [REG_W-1:0]    dest_q,
   output logic [STATUS_W-1:0] status,
   output logic                carry_to_alu,
   output logic [CNT_W-1:0]    retired_cnt,
   output logic [CNT_W-1:0]    stall_cnt
);

   logic                r_valid;
   logic [DATA_W-1:0]   r_alu_result;
   logic [DATA_W-1:0]   r_val_rm;
   logic [DATA_W-1:0]   r_pc;
   exmem_ctrl_t         r_ctrl;
   logic [CNT_W-1:0]    r_retired;
   logic [CNT_W-1:0]    r_stall;

   logic                w_accept;
   logic                w_stall;
   logic [STATUS_W-1:0] w_flags;

   // Slot is free when empty or being emptied this cycle
   assign ready_out = ~r_valid | ready_in;
   assign w_accept  = valid_in & ready_out & ~flush;
   assign w_stall   = r_valid & ~ready_in;
   assign w_flags   = pack_nzcv(flag_n, flag_z, flag_c, flag_v);

   // Pipeline register: flush beats accept; accept beats drain
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_valid      <= 1'b0;
         r_alu_result <= '0;
         r_val_rm     <= '0;
         r_pc         <= '0;
         r_ctrl       <= '0;
      end else if (flush) begin
         r_valid <= 1'b0;
      end else if (w_accept) begin
         r_valid         <= 1'b1;
         r_alu_result    <= alu_result;
         r_val_rm        <= val_rm;
         r_pc            <= pc_in;
         r_ctrl.wb_en    <= wb_en;
         r_ctrl.mem_r_en <= mem_r_en;
         r_ctrl.mem_w_en <= mem_w_en;
         r_ctrl.dest     <= REG_W_DEF'(dest);
      end else if (ready_in) begin
         r_valid <= 1'b0;
      end
   end

   // Performance counters, wrapping naturally
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_retired <= '0;
         r_stall   <= '0;
      end else begin
         if (w_accept) r_retired <= r_retired + CNT_W'(1);
         if (w_stall)  r_stall   <= r_stall + CNT_W'(1);
      end
   end

   status_reg u_status_reg (
      .clk      (clk),
      .rst      (rst),
      .i_load   (w_accept & s_bit),
      .i_flags  (w_flags),
      .o_status (status),
      .o_carry  (carry_to_alu)
   );

   assign valid_out    = r_valid;
   assign alu_result_q = r_alu_result;
   assign val_rm_q     = r_val_rm;
   assign pc_q         = r_pc;
   assign wb_en_q      = r_ctrl.wb_en;
   assign mem_r_en_q   = r_ctrl.mem_r_en;
   assign mem_w_en_q   = r_ctrl.mem_w_en;
   assign dest_q       = REG_W'(r_ctrl.dest);
   assign retired_cnt  = r_retired;
   assign stall_cnt    = r_stall;

endmodule
